ps2_key_command_scheduler: RTL and testbench
============================================

Name: ps2_key_command_scheduler

Overview:
- Sits between the PS/2 byte receiver (received_data / received_data_en strobe) and the Tetris game logic.
- Parses scan-code sequences (E0 extended prefix, F0 break prefix) into game commands and tracks which keys are held.
- Generates auto-repeat for held movement keys and buffers commands in a small FIFO with a valid/ready handshake, so a busy game FSM never loses a keypress.

Parameters:
DELAY_CYCLES, 12500000, cycles from make to first auto-repeat (250 ms at 50 MHz)
PERIOD_CYCLES, 2500000, cycles between subsequent auto-repeats (50 ms)
FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous active-high reset
received_data  in  8  scan-code byte from PS/2 receiver
received_data_en  in  1  one-cycle strobe; received_data valid this cycle
cmd_ready  in  1  game logic accepts head command this cycle
cmd_valid  out  1  FIFO non-empty
cmd_code  out  3  head command: 1 ROTATE, 2 LEFT, 3 RIGHT, 4 DOWN, 5 DROP (0 when empty)
keys_held  out  5  bit0 up, bit1 left, bit2 right, bit3 down, bit4 space
overflow  out  1  sticky; set when a command is dropped because the FIFO is full

Behaviour:
- Reset (async, any time, including mid-sequence) forces the following; the parser restarts cleanly at the next byte after release:
  - parser to IDLE
  - keys_held=0, FIFO empty, cmd_valid=0, cmd_code=0, overflow=0
  - repeat counter=0, repeat_pending=0
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK. A state advances only on received_data_en.
  - byte E0: from any state -> EXT.
  - byte F0: IDLE->BRK, EXT->EXT_BRK; BRK and EXT_BRK stay put.
  - any other byte: decode per the rules below, then -> IDLE.
- Key map:
  - EXT: 75=up, 6B=left, 74=right, 72=down.
  - IDLE/BRK: 29=space.
  - Any other byte is ignored, with no command generated.
- Make (IDLE or EXT, mapped key):
  - key not held: set its keys_held bit and enqueue its command (up->ROTATE, space->DROP, others as named).
  - key already held (keyboard typematic): no command.
- Break (BRK or EXT_BRK, mapped key): clear its keys_held bit; no command. Break of a key that is not held has no effect.
- Decode latency: the command is written on the clock edge after the final byte's strobe; cmd_valid rises on the following cycle when the FIFO was empty.
- Auto-repeat (LEFT, RIGHT, DOWN only):
  - repeat key = highest-priority held key among left > right > down.
  - counter restarts to 0 on any keys_held change; idle when no repeat key is held.
  - when the counter reaches DELAY_CYCLES-1, raise a repeat request for the repeat key. After that, raise one every PERIOD_CYCLES.
  - ROTATE and DROP never repeat.
- Enqueue arbitration: a decode enqueue and a repeat request in the same cycle -> decode enqueues first, the repeat is held in repeat_pending and enqueues next cycle. At most one push per cycle.
- FIFO:
  - cmd_code is the head entry; pop when cmd_valid & cmd_ready.
  - push when full without a same-cycle pop: drop the command and set overflow.
  - push and pop in the same cycle when full: both succeed, no overflow.
  - pointers wrap modulo FIFO_DEPTH; count is tracked explicitly (FIFO_DEPTH+1 states).
- Counters are wide enough for max(DELAY_CYCLES, PERIOD_CYCLES); no wrap occurs before the terminal compare.

Test Plan:
- Bench parameters: DELAY_CYCLES=20, PERIOD_CYCLES=5, FIFO_DEPTH=4.
- E0,75 with cmd_ready=1 -> one ROTATE (code 1), keys_held=00001; then E0,F0,75 -> keys_held=0, no command; repeated E0,75 typematic while held -> no extra commands.
- E0,6B held 40 cycles, cmd_ready=1 -> LEFT at make, then LEFT repeats 20 cycles later and every 5 cycles after; E0,F0,6B -> repeats stop.
- Left and right held together -> repeats are LEFT; release left -> counter restarts and a RIGHT repeat arrives 20 cycles later.
- cmd_ready=0, five distinct makes (29, E0 75, E0 6B, E0 74, E0 72) -> FIFO holds DROP, ROTATE, LEFT, RIGHT; DOWN dropped, overflow=1 (sticky); drain yields codes 5,1,2,3 in order.
- Repeat request coinciding with the final byte of a make -> decoded command first, repeat next cycle, both present in the FIFO.
- Assert reset after E0,F0 (mid-sequence) with held keys and a non-empty FIFO -> all outputs 0 asynchronously; after release, byte 29 produces a make DROP, not a break.

Source files
------------

// File: rtl/ps2_key_command_scheduler.sv
// PS/2 scan-code parser -> Tetris commands, with held-key tracking, auto-repeat and a command FIFO.
// Command enters the FIFO on the edge that samples the final byte; cmd_valid/cmd_ready pop, full FIFO drops and flags overflow.
module ps2_key_command_scheduler #(
    parameter int DELAY_CYCLES  = 12500000,
    parameter int PERIOD_CYCLES = 2500000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [4:0] keys_held,
    output logic       overflow
);

    localparam int MAX_CYC = (DELAY_CYCLES > PERIOD_CYCLES) ? DELAY_CYCLES : PERIOD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DELAY_TERM  = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] PERIOD_TERM = CW'(PERIOD_CYCLES - 1);
    localparam logic [NW-1:0] FULL_COUNT  = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t          state_q, state_d;
    logic [4:0]      keys_q, keys_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            first_q, first_d;
    logic            pend_q, pend_d;
    logic [2:0]      pend_cmd_q, pend_cmd_d;
    logic            ovf_q, ovf_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]   count_q, count_d;
    logic [2:0]      mem_q [FIFO_DEPTH];

    logic            is_ext, is_brk;
    logic            key_hit;
    logic [2:0]      key_idx;
    logic            dec_push;
    logic [2:0]      dec_cmd;
    logic            rep_vld, rep_req;
    logic [2:0]      rep_cmd;
    logic [CW-1:0]   rep_term;
    logic            push;
    logic [2:0]      push_cmd;
    logic            pop, full, wr_en;

    assign is_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    assign is_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);

    always_comb begin
        state_d  = state_q;
        keys_d   = keys_q;
        key_hit  = 1'b0;
        key_idx  = 3'd0;
        dec_push = 1'b0;
        dec_cmd  = 3'd0;
        if (received_data_en) begin
            if (received_data == 8'hE0) begin
                state_d = S_EXT;
            end else if (received_data == 8'hF0) begin
                if (state_q == S_IDLE) state_d = S_BRK;
                else if (state_q == S_EXT) state_d = S_EXT_BRK;
            end else begin
                state_d = S_IDLE;
                if (is_ext) begin
                    case (received_data)
                        8'h75:   begin key_hit = 1'b1; key_idx = 3'd0; end
                        8'h6B:   begin key_hit = 1'b1; key_idx = 3'd1; end
                        8'h74:   begin key_hit = 1'b1; key_idx = 3'd2; end
                        8'h72:   begin key_hit = 1'b1; key_idx = 3'd3; end
                        default: key_hit = 1'b0;
                    endcase
                end else if (received_data == 8'h29) begin
                    key_hit = 1'b1;
                    key_idx = 3'd4;
                end
                if (key_hit) begin
                    if (is_brk) begin
                        keys_d[key_idx] = 1'b0;
                    end else if (!keys_q[key_idx]) begin
                        // Typematic repeats of an already-held key are swallowed here.
                        keys_d[key_idx] = 1'b1;
                        dec_push        = 1'b1;
                        dec_cmd         = key_idx + 3'd1;
                    end
                end
            end
        end
    end

    assign rep_vld  = keys_q[1] | keys_q[2] | keys_q[3];
    assign rep_cmd  = keys_q[1] ? 3'd2 : (keys_q[2] ? 3'd3 : 3'd4);
    assign rep_term = first_q ? PERIOD_TERM : DELAY_TERM;
    assign rep_req  = rep_vld && (cnt_q == rep_term);

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        first_d = first_q;
        if ((keys_d != keys_q) || !rep_vld) begin
            cnt_d   = '0;
            first_d = 1'b0;
        end else if (rep_req) begin
            cnt_d   = '0;
            first_d = 1'b1;
        end
    end

    // Decode wins the single push slot; a colliding repeat waits one cycle in pend.
    always_comb begin
        push       = 1'b0;
        push_cmd   = 3'd0;
        pend_d     = pend_q;
        pend_cmd_d = pend_cmd_q;
        if (dec_push) begin
            push     = 1'b1;
            push_cmd = dec_cmd;
            if (rep_req) begin
                pend_d     = 1'b1;
                pend_cmd_d = rep_cmd;
            end
        end else if (pend_q) begin
            push       = 1'b1;
            push_cmd   = pend_cmd_q;
            pend_d     = rep_req;
            pend_cmd_d = rep_cmd;
        end else if (rep_req) begin
            push     = 1'b1;
            push_cmd = rep_cmd;
        end
    end

    assign pop   = (count_q != '0) && cmd_ready;
    assign full  = (count_q == FULL_COUNT);
    assign wr_en = push && (!full || pop);
    assign ovf_d = ovf_q | (push && full && !pop);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) count_d = count_q + NW'(1);
        else if (!wr_en && pop) count_d = count_q - NW'(1);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            keys_q     <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_cmd_q <= 3'd0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            keys_q     <= keys_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            pend_q     <= pend_d;
            pend_cmd_q <= pend_cmd_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_cmd;
    end

    assign cmd_valid = (count_q != '0);
    assign cmd_code  = cmd_valid ? mem_q[rd_ptr_q] : 3'd0;
    assign keys_held = keys_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_command_scheduler.sv
// Bench for ps2_key_command_scheduler: directed scan-code scenarios plus random bytes against a queue-based model.
module tb_ps2_key_command_scheduler;

    localparam int DLY   = 20;
    localparam int PER   = 5;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       en;
    logic       ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [4:0] keys_held;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ps2_key_command_scheduler #(
        .DELAY_CYCLES (DLY),
        .PERIOD_CYCLES(PER),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLOCK_50        (clk),
        .reset           (rst),
        .received_data   (data),
        .received_data_en(en),
        .cmd_ready       (ready),
        .cmd_valid       (cmd_valid),
        .cmd_code        (cmd_code),
        .keys_held       (keys_held),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state: expected FIFO contents, held keys, parser prefixes.
    int         mq[$];
    logic [4:0] m_held;
    logic       m_ovf;
    int         m_ext, m_brk;
    int         pend;
    int         cyc = 0;
    int         t_change = 0;

    function automatic int key_of(input logic [7:0] b, input int ext);
        if (ext != 0) begin
            case (b)
                8'h75:   return 0;
                8'h6B:   return 1;
                8'h74:   return 2;
                8'h72:   return 3;
                default: return -1;
            endcase
        end
        return (b == 8'h29) ? 4 : -1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin : model
        int         rk, el, rep, dec, k, pushv;
        logic [4:0] old;
        bit         popv, fullv;
        if (rst) begin
            mq.delete();
            m_held   = '0;
            m_ovf    = 1'b0;
            m_ext    = 0;
            m_brk    = 0;
            pend     = 0;
            t_change = cyc;
        end else begin
            cyc++;
            old = m_held;
            rk  = m_held[1] ? 2 : (m_held[2] ? 3 : (m_held[3] ? 4 : 0));
            el  = cyc - t_change;
            rep = (rk != 0 && el >= DLY && ((el - DLY) % PER) == 0) ? rk : 0;
            dec = 0;
            if (en) begin
                if (data == 8'hE0) begin
                    m_ext = 1;
                    m_brk = 0;
                end else if (data == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    k = key_of(data, m_ext);
                    if (k >= 0) begin
                        if (m_brk != 0) m_held[k] = 1'b0;
                        else if (!m_held[k]) begin
                            m_held[k] = 1'b1;
                            dec = k + 1;
                        end
                    end
                    m_ext = 0;
                    m_brk = 0;
                end
            end
            if (m_held != old) t_change = cyc;
            pushv = 0;
            if (dec != 0) begin
                pushv = dec;
                if (rep != 0) pend = rep;
            end else if (pend != 0) begin
                pushv = pend;
                pend  = rep;
            end else begin
                pushv = rep;
            end
            popv  = ready && (mq.size() > 0);
            fullv = (mq.size() == DEPTH);
            if (popv) void'(mq.pop_front());
            if (pushv != 0) begin
                if (fullv && !popv) m_ovf = 1'b1;
                else mq.push_back(pushv);
            end
        end
    end

    always @(negedge clk) begin : monitor
        int head;
        head = (mq.size() > 0) ? mq[0] : 0;
        check("cmd_valid", 8'(cmd_valid), 8'(mq.size() > 0));
        check("cmd_code", 8'(cmd_code), 8'(head));
        check("keys_held", 8'(keys_held), 8'(m_held));
        check("overflow", 8'(overflow), 8'(m_ovf));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        data = b;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic send_ext(input logic [7:0] b, input bit brk);
        send(8'hE0);
        if (brk) send(8'hF0);
        send(b);
    endtask

    logic [7:0] pool [8];

    initial begin
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h74, 8'h72, 8'h29, 8'h1C};
        rst   = 1'b1;
        data  = 8'h00;
        en    = 1'b0;
        ready = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Rotate: make, typematic, break.
        ready = 1'b1;
        send_ext(8'h75, 0);
        idle(3);
        send_ext(8'h75, 0);
        idle(2);
        send_ext(8'h75, 0);
        idle(2);
        send_ext(8'h75, 1);
        idle(3);

        // Left auto-repeat, then release.
        send_ext(8'h6B, 0);
        idle(40);
        send_ext(8'h6B, 1);
        idle(30);

        // Left over right priority; releasing left restarts toward a right repeat.
        send_ext(8'h6B, 0);
        send_ext(8'h74, 0);
        idle(30);
        send_ext(8'h6B, 1);
        idle(30);
        send_ext(8'h74, 1);
        idle(5);

        // Overflow with a stalled consumer, then drain.
        ready = 1'b0;
        send(8'h29);
        send_ext(8'h75, 0);
        send_ext(8'h6B, 0);
        send_ext(8'h74, 0);
        send_ext(8'h72, 0);
        idle(3);
        ready = 1'b1;
        idle(8);
        send(8'hF0);
        send(8'h29);
        send_ext(8'h75, 1);
        send_ext(8'h6B, 1);
        send_ext(8'h74, 1);
        send_ext(8'h72, 1);
        idle(5);

        // Repeat request lands on the same edge as a space make.
        ready = 1'b0;
        send_ext(8'h6B, 0);
        idle(DLY - 1);
        send(8'h29);
        idle(3);
        ready = 1'b1;
        idle(4);
        send(8'hF0);
        send(8'h29);
        send_ext(8'h6B, 1);
        idle(3);

        // Async reset mid-sequence with keys held and FIFO non-empty.
        ready = 1'b0;
        send_ext(8'h6B, 0);
        send(8'h29);
        idle(2);
        send(8'hE0);
        send(8'hF0);
        #3;
        rst = 1'b1;
        #1;
        check("rst_cmd_valid", 8'(cmd_valid), 8'd0);
        check("rst_cmd_code", 8'(cmd_code), 8'd0);
        check("rst_keys_held", 8'(keys_held), 8'd0);
        check("rst_overflow", 8'(overflow), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        ready = 1'b1;
        send(8'h29);
        idle(3);
        check("post_rst_space_held", 8'(keys_held), 8'h10);
        send(8'hF0);
        send(8'h29);
        idle(2);

        // Random byte stream with a randomly stalling consumer.
        for (int i = 0; i < 300; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            send(pool[$urandom_range(0, 7)]);
            idle($urandom_range(0, 6));
        end
        ready = 1'b1;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
